product_bcd_formatter: RTL and testbench

- Downstream stage of the signed Booth multiplier. It consumes the 8-bit two's-complement product (AQ) when the multiplier's completion flag pulses.
- Converts the product to sign plus 3-digit BCD magnitude for the display/readout path.
- Uses a sequential shift-add-3 (double-dabble) engine, one bit per clock, with a valid/ready input and a one-cycle result strobe.

---
 rtl/booth_pkg.sv | 25 ++
 rtl/bcd_digit_adj.sv | 12 +
 rtl/product_bcd_formatter.sv | 88 ++++++++
 tb/tb_product_bcd_formatter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Definitions shared by the Booth multiplier and its downstream BCD formatter:
// default widths, the formatter state encoding and the double-dabble constants.
package booth_pkg;

  localparam int BOOTH_W  = 8;
  localparam int BOOTH_ND = 3;

  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
  localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

  typedef enum logic [1:0] {
    IDLE,
    ABS,
    SHIFT
  } state_t;

  // Used at elaboration to prove ND digits can hold the largest magnitude.
  function automatic longint unsigned pow10(input int n);
    longint unsigned r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One double-dabble correction cell: a digit of 5 or more gets +3 so that the
// following left shift carries correctly into the next decimal digit.
module bcd_digit_adj
  import booth_pkg::*;
(
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= BCD_ADJ_THRESH) ? (din + BCD_ADJ_ADD) : din;

endmodule

// File: rtl/product_bcd_formatter.sv
// Converts a signed Booth product into sign plus ND-digit BCD magnitude using
// a bit-serial shift-add-3 engine; one product in flight at a time.
module product_bcd_formatter
  import booth_pkg::*;
#(
  parameter int W  = BOOTH_W,
  parameter int ND = BOOTH_ND
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W-1:0]      product,
  output logic              out_valid,
  output logic              sign,
  output logic [4*ND-1:0]   bcd
);

  localparam int SW = 4*ND + W;
  localparam int CW = $clog2(W + 1);

  // The magnitude of -2^(W-1) must still fit in ND decimal digits.
  if (pow10(ND) <= (64'd1 << (W - 1))) begin : g_bad_params
    $error("product_bcd_formatter: ND digits too few for W-bit products");
  end

  state_t          state;
  logic [W-1:0]    p_reg;
  logic            s_reg;
  logic [SW-1:0]   sh_reg;
  logic [SW-1:0]   sh_next;
  logic [CW-1:0]   cnt;
  logic [W-1:0]    mag;
  logic [4*ND-1:0] adj_digits;

  for (genvar i = 0; i < ND; i++) begin : g_adj
    bcd_digit_adj u_adj (
      .din  (sh_reg[W + 4*i +: 4]),
      .dout (adj_digits[4*i +: 4])
    );
  end

  assign sh_next  = {adj_digits, sh_reg[W-1:0]} << 1;
  assign mag      = p_reg[W-1] ? (~p_reg + {{(W-1){1'b0}}, 1'b1}) : p_reg;
  assign in_ready = (state == IDLE);

  // The completing edge publishes sh_next directly, since sh_reg is one shift behind.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      p_reg     <= '0;
      s_reg     <= 1'b0;
      sh_reg    <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      sign      <= 1'b0;
      bcd       <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            p_reg <= product;
            state <= ABS;
          end
        end
        ABS: begin
          s_reg  <= p_reg[W-1];
          sh_reg <= {{(4*ND){1'b0}}, mag};
          cnt    <= CW'(W);
          state  <= SHIFT;
        end
        SHIFT: begin
          sh_reg <= sh_next;
          cnt    <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            sign      <= s_reg;
            bcd       <= sh_next[SW-1:W];
            out_valid <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_product_bcd_formatter.sv
// Scoreboard bench for product_bcd_formatter: each accepted product queues a
// reference sign/BCD/acceptance-edge, checked when out_valid strobes.
module tb_product_bcd_formatter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  product = 8'h00;
  logic        out_valid;
  logic        sign;
  logic [11:0] bcd;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  typedef struct {
    logic        s;
    logic [11:0] b;
    int          acc;
  } exp_t;

  exp_t sb[$];

  product_bcd_formatter #(.W(8), .ND(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .product   (product),
    .out_valid (out_valid),
    .sign      (sign),
    .bcd       (bcd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [11:0] refBcd(input logic [7:0] p);
    int v;
    v = p[7] ? (256 - int'(p)) : int'(p);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Acceptance is seen the half-cycle before its edge, so that edge is cyc + 1.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset) begin
      sb.delete();
    end else begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          checkOutput("spurious_out_valid", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          checkOutput("sb_sign", {31'd0, sign}, {31'd0, e.s});
          checkOutput("sb_bcd", {20'd0, bcd}, {20'd0, e.b});
          checkOutput("sb_latency", cyc - e.acc, 32'd9);
        end
      end
      if (in_valid && in_ready) begin
        e.s   = product[7];
        e.b   = refBcd(product);
        e.acc = cyc + 1;
        sb.push_back(e);
      end
    end
  end

  task automatic applyStimulus(input logic [7:0] p);
    in_valid = 1'b1;
    product  = p;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    product  = 8'($urandom);
  endtask

  task automatic waitDrain();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) checkOutput("drain_timeout", sb.size(), 32'd0);
  endtask

  task automatic checkHeld(input string tag, input logic s, input logic [11:0] b);
    checkOutput({tag, "_sign"}, {31'd0, sign}, {31'd0, s});
    checkOutput({tag, "_bcd"}, {20'd0, bcd}, {20'd0, b});
  endtask

  task automatic runOne(input logic [7:0] p, input logic s, input logic [11:0] b, input string tag);
    applyStimulus(p);
    waitDrain();
    checkHeld(tag, s, b);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkHeld("rst", 1'b0, 12'h000);
    reset = 1'b0;
    @(posedge clk);
    #1;

    applyStimulus(8'b00001100);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("busy_in_ready", {31'd0, in_ready}, 32'd0);
    waitDrain();
    checkHeld("p12", 1'b0, 12'h012);
    @(posedge clk);
    #1;

    runOne(8'b11101000, 1'b1, 12'h024, "m24");
    runOne(8'b11110000, 1'b1, 12'h016, "m16");
    runOne(8'b00010100, 1'b0, 12'h020, "p20");
    runOne(8'h80, 1'b1, 12'h128, "m128");
    runOne(8'h7F, 1'b0, 12'h127, "p127");
    runOne(8'h00, 1'b0, 12'h000, "zero");
    runOne(8'hFF, 1'b1, 12'h001, "m1");

    // A request while busy must be dropped, not queued.
    applyStimulus(8'h40);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reject_in_ready", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b1;
    product  = 8'h99;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    waitDrain();
    checkHeld("p64", 1'b0, 12'h064);
    repeat (12) @(posedge clk);
    #1;
    checkOutput("reject_no_strobe", {31'd0, out_valid}, 32'd0);
    checkHeld("p64_hold", 1'b0, 12'h064);

    in_valid = 1'b1;
    product  = 8'h05;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!out_valid && n < 40);
    if (!out_valid) checkOutput("b2b_timeout", 32'd0, 32'd1);
    product = 8'hFB;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checkOutput("b2b_accepted", {31'd0, in_ready}, 32'd0);
    waitDrain();
    checkHeld("b2b_m5", 1'b1, 12'h005);
    @(posedge clk);
    #1;

    applyStimulus(8'hC8);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    checkHeld("midrst", 1'b0, 12'h000);
    reset = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    checkOutput("midrst_no_stale", {31'd0, out_valid}, 32'd0);
    checkHeld("midrst_hold", 1'b0, 12'h000);
    runOne(8'hC8, 1'b1, 12'h056, "m56");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
